// File: rtl/cic_integrator_decim_if.sv
// Sample stream bundle between a sample source and the CIC integrator/decimator.
//   i_en    : input sample valid (source -> filter)
//   i_data  : signed input sample (source -> filter)
//   o_data  : decimated integrator output, signed (filter -> sink)
//   o_valid : one-cycle strobe marking a new o_data (filter -> sink)
// master = sample source / consumer side, slave = filter side.
interface cic_integrator_decim_if #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 20
);
    logic                        i_en;
    logic signed [IN_WIDTH-1:0]  i_data;
    logic signed [OUT_WIDTH-1:0] o_data;
    logic                        o_valid;

    modport master (
        output i_en,
        output i_data,
        input  o_data,
        input  o_valid
    );

    modport slave (
        input  i_en,
        input  i_data,
        output o_data,
        output o_valid
    );
endinterface

// File: rtl/cic_integrator_decim.sv
// Integrator and decimation front end of a CIC decimation filter.
// A cascade of STAGES pipelined two's-complement integrators runs at the input
// rate; every DECIM-th accepted sample the last integrator value is latched to
// o_data and o_valid pulses for one cycle to enable the downstream comb chain.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : slave side of the sample bundle (i_en, i_data in; o_data, o_valid out)
module cic_integrator_decim #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned DECIM     = 16,
    parameter int unsigned OUT_WIDTH = 20
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    cic_integrator_decim_if.slave  bus
);
    localparam int unsigned CntW = $clog2(DECIM);

    logic signed [OUT_WIDTH-1:0] integ_q [STAGES];
    logic signed [OUT_WIDTH-1:0] integ_d [STAGES];
    logic        [CntW-1:0]      cnt_q, cnt_d;
    logic signed [OUT_WIDTH-1:0] o_data_q, o_data_d;
    logic                        o_valid_q, o_valid_d;
    logic signed [OUT_WIDTH-1:0] x_ext;
    logic                        frame_end;

    // Sized cast of a signed operand sign-extends.
    assign x_ext     = OUT_WIDTH'(bus.i_data);
    assign frame_end = bus.i_en && (cnt_q == CntW'(DECIM - 1));

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            integ_d[k] = integ_q[k];
        end
        cnt_d     = cnt_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;

        if (bus.i_en) begin
            // Each stage adds the pre-edge value of its predecessor: one register
            // per stage, no carry chain across stages. Wrap-around is intended.
            integ_d[0] = integ_q[0] + x_ext;
            for (int k = 1; k < STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end

            if (frame_end) begin
                cnt_d     = '0;
                o_data_d  = integ_d[STAGES-1];
                o_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q     <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= integ_d[k];
            end
            cnt_q     <= cnt_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;
endmodule
